// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch channel between pc_fetch_unit and instruction memory.
//   imem_req   : fetch request, imem_addr valid while high (driven by fetch unit)
//   imem_addr  : 32-bit fetch address (driven by fetch unit)
//   imem_ack   : imem_rdata valid this cycle (driven by memory)
//   imem_rdata : 32-bit fetched instruction word (driven by memory)
// Modports: master = fetch unit side, slave = memory side.
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program-counter stage: forms the next PC (sequential / branch / JAL / JALR), holds the PC
// register and runs a req/ack fetch handshake to instruction memory. One latched
// instruction per fetch is presented to decode/execute, with stall support.
//
// Ports:
//   clk, rst          : clock (rising edge), synchronous active-high reset
//   branch_sel[1:0]   : [0] conditional branch taken, [1] jump (bit 1 has priority)
//   jalr              : jump is JALR (rs1-based) when 1, JAL when 0
//   imm, rs1_data     : sign-extended immediate, JALR base register
//   stall             : hold current instruction and PC
//   imem              : fetch channel (master modport of pc_fetch_unit_if)
//   inst_out          : latched instruction for decode
//   inst_valid        : inst_out / pc_out valid
//   pc_out, pc_plus4  : PC of inst_out and its link value
//   misalign_trap     : one-cycle pulse on misaligned redirect (0 unless macro set)
//
// Configuration macro: MISALIGN_TRAP_EN
//   defined   : redirect target with bit 1 set sends the PC to TRAP_VEC and pulses
//               misalign_trap for one cycle.
//   undefined : redirect targets are forced word-aligned; misalign_trap is tied low.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             branch_sel,
  input  logic                   jalr,
  input  logic [31:0]            imm,
  input  logic [31:0]            rs1_data,
  input  logic                   stall,
  pc_fetch_unit_if.master        imem,
  output logic [31:0]            inst_out,
  output logic                   inst_valid,
  output logic [31:0]            pc_out,
  output logic [31:0]            pc_plus4,
  output logic                   misalign_trap
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StExec
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;

  logic [31:0] seq_pc;
  logic [31:0] target;
  logic        redirect;
  logic [31:0] next_pc;
  logic        trap_hit;

  // Target of a taken branch / jump; JALR clears bit 0 of its sum.
  always_comb begin
    seq_pc   = pc_q + 32'd4;
    redirect = (branch_sel != 2'b00);
    if (branch_sel[1] && jalr) begin
      target = (rs1_data + imm) & ~32'h1;
    end else begin
      target = pc_q + imm;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic trap_q;

  always_comb begin
    trap_hit = 1'b0;
    if (redirect && target[1]) begin
      next_pc  = TRAP_VEC;
      trap_hit = 1'b1;
    end else if (redirect) begin
      next_pc = target;
    end else begin
      next_pc = seq_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trap_q <= 1'b0;
    end else begin
      // Pulses only in the cycle after the S_EXEC decision that redirected.
      trap_q <= (state_q == StExec) && !stall && trap_hit;
    end
  end

  assign misalign_trap = trap_q;
`else
  logic unused_trap_vec;

  always_comb begin
    trap_hit = 1'b0;
    next_pc  = redirect ? (target & ~32'h3) : seq_pc;
  end

  assign unused_trap_vec = ^{TRAP_VEC, trap_hit};
  assign misalign_trap   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    case (state_q)
      StIdle: begin
        state_d = StReq;
      end
      StReq: begin
        // Zero-wait memory may ack in the first request cycle.
        if (imem.imem_ack) begin
          inst_d  = imem.imem_rdata;
          valid_d = 1'b1;
          state_d = StExec;
        end
      end
      StExec: begin
        // Stall wins over a same-cycle redirect; branch_sel is re-read once it drops.
        if (!stall) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
          state_d = StReq;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  assign imem.imem_req  = (state_q == StReq);
  assign imem.imem_addr = pc_q;
  assign inst_out       = inst_q;
  assign inst_valid     = valid_q;
  assign pc_out         = pc_q;
  assign pc_plus4       = seq_pc;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;
  logic        clk;
  logic        rst;
  logic [1:0]  branch_sel;
  logic        jalr;
  logic [31:0] imm;
  logic [31:0] rs1_data;
  logic        stall;
  logic [31:0] inst_out;
  logic        inst_valid;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        misalign_trap;

  int checks = 0;
  int errors = 0;

  pc_fetch_unit_if mif ();

  pc_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .branch_sel   (branch_sel),
    .jalr         (jalr),
    .imm          (imm),
    .rs1_data     (rs1_data),
    .stall        (stall),
    .imem         (mif),
    .inst_out     (inst_out),
    .inst_valid   (inst_valid),
    .pc_out       (pc_out),
    .pc_plus4     (pc_plus4),
    .misalign_trap(misalign_trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish got=timeout exp=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a request, then acks it with the given word.
  task automatic fetch(input logic [31:0] word);
    int n = 0;
    while (!mif.imem_req && n < 10) begin
      tick();
      n++;
    end
    if (!mif.imem_req) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout got=req_low exp=req_high");
    end
    mif.imem_ack   = 1'b1;
    mif.imem_rdata = word;
    tick();
    mif.imem_ack   = 1'b0;
    mif.imem_rdata = 32'h0;
  endtask

  // Leaves S_EXEC with the given redirect controls.
  task automatic execute(input logic [1:0] bs, input logic j, input logic [31:0] im,
                         input logic [31:0] rs);
    branch_sel = bs;
    jalr       = j;
    imm        = im;
    rs1_data   = rs;
    stall      = 1'b0;
    tick();
    branch_sel = 2'b00;
    jalr       = 1'b0;
    imm        = 32'h0;
    rs1_data   = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (mif.imem_req !== 1'b0) begin
      errors++; $display("FAIL reset_req got=%b exp=0", mif.imem_req);
    end
    checks++;
    if (inst_valid !== 1'b0 || inst_out !== 32'h0) begin
      errors++; $display("FAIL reset_inst got=%b/%h exp=0/00000000", inst_valid, inst_out);
    end
    checks++;
    if (pc_out !== 32'h0) begin
      errors++; $display("FAIL reset_pc got=%h exp=00000000", pc_out);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (mif.imem_req !== 1'b1 || mif.imem_addr !== 32'h0) begin
      errors++; $display("FAIL first_req got=%b/%h exp=1/00000000", mif.imem_req, mif.imem_addr);
    end
    // Zero-wait ack in the first request cycle.
    mif.imem_ack = 1'b1; mif.imem_rdata = 32'h0000_0013;
    tick();
    mif.imem_ack = 1'b0;
    checks++;
    if (inst_valid !== 1'b1 || inst_out !== 32'h0000_0013) begin
      errors++; $display("FAIL first_inst got=%b/%h exp=1/00000013", inst_valid, inst_out);
    end
  endtask

  task automatic test_branch();
    execute(2'b01, 1'b0, 32'h0000_0100, 32'h0);
    checks++;
    if (mif.imem_addr !== 32'h0000_0100 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL br_to_100 got=%h/%b exp=00000100/0", mif.imem_addr, inst_valid);
    end
    fetch(32'hAAAA_0001);
    checks++;
    if (pc_plus4 !== 32'h0000_0104) begin
      errors++; $display("FAIL pc_plus4_100 got=%h exp=00000104", pc_plus4);
    end
    execute(2'b01, 1'b0, 32'hFFFF_FFF8, 32'h0);
    checks++;
    if (mif.imem_addr !== 32'h0000_00F8) begin
      errors++; $display("FAIL br_minus8 got=%h exp=000000f8", mif.imem_addr);
    end
    fetch(32'hAAAA_0002);
    execute(2'b01, 1'b0, 32'h0000_0008, 32'h0);
    fetch(32'hAAAA_0003);
    execute(2'b00, 1'b0, 32'h0000_0040, 32'h0);
    checks++;
    if (mif.imem_addr !== 32'h0000_0104) begin
      errors++; $display("FAIL seq_plus4 got=%h exp=00000104", mif.imem_addr);
    end
  endtask

  task automatic test_jump();
    fetch(32'hBBBB_0001);
    checks++;
    if (pc_plus4 !== 32'h0000_0108 || pc_out !== 32'h0000_0104) begin
      errors++; $display("FAIL link_value got=%h/%h exp=00000104/00000108", pc_out, pc_plus4);
    end
    execute(2'b11, 1'b1, 32'h0000_0004, 32'h0000_2001);
    checks++;
    if (mif.imem_addr !== 32'h0000_2004) begin
      errors++; $display("FAIL jalr_target got=%h exp=00002004", mif.imem_addr);
    end
    fetch(32'hBBBB_0002);
    execute(2'b11, 1'b0, 32'h0000_0010, 32'hFFFF_0000);
    checks++;
    if (mif.imem_addr !== 32'h0000_2014) begin
      errors++; $display("FAIL jal_prio got=%h exp=00002014", mif.imem_addr);
    end
    fetch(32'hBBBB_0003);
    execute(2'b10, 1'b1, 32'h0000_0000, 32'hFFFF_FFFC);
    fetch(32'hBBBB_0004);
    execute(2'b00, 1'b0, 32'h0, 32'h0);
    checks++;
    if (mif.imem_addr !== 32'h0000_0000) begin
      errors++; $display("FAIL pc_wrap got=%h exp=00000000", mif.imem_addr);
    end
  endtask

  task automatic test_stall();
    fetch(32'hCCCC_0001);
    stall = 1'b1; branch_sel = 2'b10; jalr = 1'b0; imm = 32'h0000_0040;
    for (int i = 0; i < 3; i++) begin
      // Stray ack outside S_REQ must not disturb the latched instruction.
      mif.imem_ack = 1'b1; mif.imem_rdata = 32'hDEAD_BEEF;
      tick();
      checks++;
      if (inst_valid !== 1'b1 || inst_out !== 32'hCCCC_0001 || pc_out !== 32'h0 ||
          mif.imem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d got=%b/%h/%h/%b exp=1/cccc0001/00000000/0", i,
                 inst_valid, inst_out, pc_out, mif.imem_req);
      end
    end
    mif.imem_ack = 1'b0;
    execute(2'b10, 1'b0, 32'h0000_0040, 32'h0);
    checks++;
    if (mif.imem_addr !== 32'h0000_0040 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL stall_release got=%h/%b exp=00000040/0", mif.imem_addr, inst_valid);
    end
  endtask

  task automatic test_wait_and_reset();
    // Request held with stable address while no ack arrives.
    tick();
    tick();
    checks++;
    if (mif.imem_req !== 1'b1 || mif.imem_addr !== 32'h0000_0040) begin
      errors++; $display("FAIL req_hold got=%b/%h exp=1/00000040", mif.imem_req, mif.imem_addr);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (mif.imem_req !== 1'b0 || mif.imem_addr !== 32'h0) begin
      errors++; $display("FAIL rst_drop_req got=%b/%h exp=0/00000000", mif.imem_req, mif.imem_addr);
    end
    // Late ack arrives while idle and must be ignored.
    mif.imem_ack = 1'b1; mif.imem_rdata = 32'hBAD0_BAD0;
    tick();
    mif.imem_ack = 1'b0; mif.imem_rdata = 32'h0;
    checks++;
    if (inst_valid !== 1'b0 || inst_out !== 32'h0 || mif.imem_req !== 1'b1) begin
      errors++; $display("FAIL late_ack got=%b/%h/%b exp=0/00000000/1", inst_valid, inst_out,
                         mif.imem_req);
    end
    fetch(32'hDDDD_0001);
    checks++;
    if (inst_out !== 32'hDDDD_0001 || pc_out !== 32'h0) begin
      errors++; $display("FAIL refetch got=%h/%h exp=dddd0001/00000000", inst_out, pc_out);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] exp_pc;
    logic        exp_trap;
`ifdef MISALIGN_TRAP_EN
    exp_pc   = 32'h0000_0100;
    exp_trap = 1'b1;
`else
    exp_pc   = 32'h0000_0100;
    exp_trap = 1'b0;
`endif
    execute(2'b10, 1'b0, 32'h0000_0102, 32'h0);
    checks++;
    if (mif.imem_addr !== exp_pc || misalign_trap !== exp_trap) begin
      errors++; $display("FAIL misalign got=%h/%b exp=%h/%b", mif.imem_addr, misalign_trap,
                         exp_pc, exp_trap);
    end
    tick();
    checks++;
    if (misalign_trap !== 1'b0) begin
      errors++; $display("FAIL trap_pulse_width got=%b exp=0", misalign_trap);
    end
  endtask

  initial begin
    rst            = 1'b1;
    branch_sel     = 2'b00;
    jalr           = 1'b0;
    imm            = 32'h0;
    rs1_data       = 32'h0;
    stall          = 1'b0;
    mif.imem_ack   = 1'b0;
    mif.imem_rdata = 32'h0;
    test_reset();
    test_branch();
    test_jump();
    test_stall();
    test_wait_and_reset();
    test_misalign();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
